// File: rtl/div16_seq_pkg.sv
// div16_seq_pkg
// Shared constants for the sequential restoring divider: the default operand
// width and the FSM state encoding used by div16_seq.
package div16_seq_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : div16_seq_pkg

// File: rtl/div16_seq_sub_trial.sv
// sub_trial
// Trial subtractor for the restoring divider: diff = a - b over WIDTH bits,
// with borrow set when b > a (the trial result would be negative).
// Ports:
//   a      - minuend (shifted partial remainder)
//   b      - subtrahend (zero-extended divisor)
//   diff   - a - b, modulo 2**WIDTH
//   borrow - 1 when a < b
module sub_trial #(
    parameter int WIDTH = 17
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH:0] full;

    // One extra bit on top catches the borrow out of the subtraction.
    assign full   = {1'b0, a} - {1'b0, b};
    assign diff   = full[WIDTH-1:0];
    assign borrow = full[WIDTH];

endmodule : sub_trial

// File: rtl/div16_seq.sv
// div16_seq
// Sequential unsigned restoring divider. One quotient bit per clock while in
// RUN, so a nonzero-divisor operation takes WIDTH cycles of RUN plus one DONE
// cycle. A zero divisor skips RUN and reports quotient=all ones,
// remainder=dividend, dz=1.
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   start     - request; only looked at in IDLE
//   dividend  - unsigned dividend, captured when start is accepted
//   divisor   - unsigned divisor, captured when start is accepted
//   busy      - high while iterating (RUN)
//   done      - one-cycle pulse, results valid
//   quotient  - unsigned quotient of the last completed operation
//   remainder - unsigned remainder of the last completed operation
//   dz        - divide-by-zero flag of the last completed operation
module div16_seq
    import div16_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;

    // Working registers: partial remainder, shifting dividend/quotient, divisor.
    logic [WIDTH-1:0] rem_w;
    logic [WIDTH-1:0] quo_w;
    logic [WIDTH-1:0] dvsr;

    // Result registers, only written on completion so RUN values stay hidden.
    logic [WIDTH-1:0] quo_out;
    logic [WIDTH-1:0] rem_out;
    logic             dz_out;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial_diff;
    logic             trial_borrow;
    logic             restore;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             accept;
    logic             last_iter;

    assign accept    = (state == IDLE) && start;
    assign last_iter = (cnt == CW'(1));

    // {R,Q} shifted left by one: the dividend MSB moves into the remainder.
    assign r_shift = {rem_w, quo_w[WIDTH-1]};

    sub_trial #(
        .WIDTH (WIDTH + 1)
    ) u_trial (
        .a      (r_shift),
        .b      ({1'b0, dvsr}),
        .diff   (trial_diff),
        .borrow (trial_borrow)
    );

    // Since R < divisor holds between iterations, a non-negative trial always
    // fits in WIDTH bits; the top diff bit is folded in only as a guard.
    assign restore  = trial_borrow | trial_diff[WIDTH];
    assign rem_next = restore ? r_shift[WIDTH-1:0] : trial_diff[WIDTH-1:0];
    assign quo_next = {quo_w[WIDTH-2:0], ~restore};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            rem_w   <= '0;
            quo_w   <= '0;
            dvsr    <= '0;
            quo_out <= '0;
            rem_out <= '0;
            dz_out  <= 1'b0;
        end else begin
            if (accept) begin
                cnt    <= CW'(WIDTH);
                rem_w  <= '0;
                quo_w  <= dividend;
                dvsr   <= divisor;
                dz_out <= 1'b0;
                if (divisor == '0) begin
                    cnt     <= '0;
                    quo_out <= '1;
                    rem_out <= dividend;
                    dz_out  <= 1'b1;
                end
            end else if (state == RUN) begin
                cnt   <= cnt - CW'(1);
                rem_w <= rem_next;
                quo_w <= quo_next;
                if (last_iter) begin
                    quo_out <= quo_next;
                    rem_out <= rem_next;
                end
            end
        end
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign quotient  = quo_out;
    assign remainder = rem_out;
    assign dz        = dz_out;

endmodule : div16_seq

// File: tb/tb_div16_seq.sv
// tb_div16_seq
// Scoreboard bench for div16_seq: the driver pushes the expected result of each
// accepted operation (from plain integer division) and the edge it was
// accepted on; the monitor pops and compares whenever done is seen.
module tb_div16_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dz;

    div16_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
        int           bsy;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   ops_done = 0;
    int   ops_sent = 0;
    int   busy_cnt = 0;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == 0) begin
            e.q   = {W{1'b1}};
            e.r   = a;
            e.dz  = 1'b1;
            e.lat = 1;
            e.bsy = 0;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dz  = 1'b0;
            e.lat = W + 1;
            e.bsy = W;
        end
        return e;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done with q=%0d r=%0d, expected none", quotient, remainder);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("dz", dz, e.dz);
                    chk("latency", cyc - a + 1, e.lat);
                    chk("busy_cycles", busy_cnt, e.bsy);
                end
                busy_cnt = 0;
                ops_done++;
            end
        end
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        exp_q.push_back(model(a, b));
        ops_sent++;
        @(posedge clk);
        #1;
        acc_q.push_back(cyc);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    task automatic wait_done(input int n);
        int t = 0;
        while (ops_done < n && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (ops_done < n) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got %0d completions, expected %0d", ops_done, n);
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #3;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_dz", dz, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed cases
        start_op(16'd100, 16'd7);     wait_done(ops_sent);
        start_op(16'hFFFF, 16'd1);    wait_done(ops_sent);
        start_op(16'hFFFF, 16'hFFFF); wait_done(ops_sent);
        start_op(16'd3, 16'd10);      wait_done(ops_sent);
        start_op(16'd5, 16'd0);       wait_done(ops_sent);

        // Start pulse mid-run is ignored; held outputs stay at the 5/0 result.
        start_op(16'd1000, 16'd3);
        repeat (4) @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 16'd9;
        divisor  = 16'd9;
        chk("hold_quotient_run", quotient, 16'hFFFF);
        chk("hold_remainder_run", remainder, 16'd5);
        chk("busy_in_run", busy, 1);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(ops_sent);

        // start held high: second op begins on the first edge back in IDLE.
        @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 16'd1234;
        divisor  = 16'd56;
        exp_q.push_back(model(16'd1234, 16'd56));
        ops_sent++;
        @(posedge clk);
        #1;
        acc_q.push_back(cyc);
        dividend = 16'd777;
        divisor  = 16'd25;
        exp_q.push_back(model(16'd777, 16'd25));
        ops_sent++;
        wait_done(ops_sent - 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        acc_q.push_back(cyc);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        wait_done(ops_sent);

        // Reset on cycle 8 of RUN aborts the operation without done.
        start_op(16'd200, 16'd9);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        ops_sent--;
        #1;
        chk("midrun_reset_busy", busy, 0);
        chk("midrun_reset_done", done, 0);
        chk("midrun_reset_quotient", quotient, 0);
        chk("midrun_reset_remainder", remainder, 0);
        chk("midrun_reset_dz", dz, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        start_op(16'd50, 16'd6);
        wait_done(ops_sent);

        // Randomized operations
        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ($urandom_range(0, 1) == 0) ? 16'd0 : W'($urandom_range(1, 3));
                1:       rb = W'($urandom_range(1, 15));
                2:       rb = W'($urandom);
                default: rb = ra ^ W'($urandom_range(0, 7));
            endcase
            start_op(ra, rb);
            if (rb != 0 && $urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 10)) @(posedge clk);
                #1;
                start    = 1'b1;
                dividend = W'($urandom);
                divisor  = W'($urandom);
                @(posedge clk);
                #1 start = 1'b0;
            end
            wait_done(ops_sent);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("completion_count", ops_done, ops_sent);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_div16_seq
